// File: rtl/axi_lite_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_initiator
//  Description : Converts a simple valid/ready command/response interface
//                into single AXI4-Lite read or write transactions, with at
//                most one transaction outstanding at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_lite_initiator #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AXI4-Lite read address / data
    output logic                  ctrl_arvalid,
    input  logic                  ctrl_arready,
    output logic [ADDR_WIDTH-1:0] ctrl_araddr,
    input  logic                  ctrl_rvalid,
    output logic                  ctrl_rready,
    input  logic [31:0]           ctrl_rdata,
    input  logic [1:0]            ctrl_rresp,
    // AXI4-Lite write address / data / response
    output logic                  ctrl_awvalid,
    input  logic                  ctrl_awready,
    output logic [ADDR_WIDTH-1:0] ctrl_awaddr,
    output logic                  ctrl_wvalid,
    input  logic                  ctrl_wready,
    output logic [31:0]           ctrl_wdata,
    output logic [3:0]            ctrl_wstrb,
    input  logic                  ctrl_bvalid,
    output logic                  ctrl_bready,
    input  logic [1:0]            ctrl_bresp
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic                  cmd_ready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  rsp_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           rdata_q;
    logic [1:0]            resp_q;
    logic                  accept;

    // cmd_ready is the registered copy, so it stays low in the first cycle
    // after reset release even though the state is already IDLE.
    assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

    // Next-state decode; write request completes once each channel has either
    // already handshaken (valid dropped) or is handshaking this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = cmd_write ? ST_WR_REQ : ST_RD_ADDR;
            ST_RD_ADDR: if (ctrl_arready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (ctrl_rvalid) state_d = ST_RSP;
            ST_WR_REQ:  if ((!awvalid_q || ctrl_awready) && (!wvalid_q || ctrl_wready))
                            state_d = ST_WR_RESP;
            ST_WR_RESP: if (ctrl_bvalid) state_d = ST_RSP;
            ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and all outputs are registered, decoded from the next state so
    // no slave input reaches an output combinationally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            arvalid_q   <= (state_d == ST_RD_ADDR);
            rready_q    <= (state_d == ST_RD_DATA);
            bready_q    <= (state_d == ST_WR_RESP);
            rsp_valid_q <= (state_d == ST_RSP);
            // AW and W drop independently after their own handshake
            awvalid_q   <= (accept && cmd_write) || (awvalid_q && !ctrl_awready);
            wvalid_q    <= (accept && cmd_write) || (wvalid_q && !ctrl_wready);
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
            if ((state_q == ST_RD_DATA) && ctrl_rvalid) begin
                rdata_q <= ctrl_rdata;
                resp_q  <= ctrl_rresp;
            end else if ((state_q == ST_WR_RESP) && ctrl_bvalid) begin
                rdata_q <= 32'd0;
                resp_q  <= ctrl_bresp;
            end
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign ctrl_arvalid = arvalid_q;
    assign ctrl_araddr  = addr_q;
    assign ctrl_rready  = rready_q;
    assign ctrl_awvalid = awvalid_q;
    assign ctrl_awaddr  = addr_q;
    assign ctrl_wvalid  = wvalid_q;
    assign ctrl_wdata   = wdata_q;
    assign ctrl_wstrb   = wstrb_q;
    assign ctrl_bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_initiator
//  Description : Directed and randomised transactions against a behavioural
//                AXI4-Lite slave with configurable per-channel stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_lite_initiator;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        ctrl_arvalid, ctrl_arready;
    logic [11:0] ctrl_araddr;
    logic        ctrl_rvalid, ctrl_rready;
    logic [31:0] ctrl_rdata;
    logic [1:0]  ctrl_rresp;
    logic        ctrl_awvalid, ctrl_awready;
    logic [11:0] ctrl_awaddr;
    logic        ctrl_wvalid, ctrl_wready;
    logic [31:0] ctrl_wdata;
    logic [3:0]  ctrl_wstrb;
    logic        ctrl_bvalid, ctrl_bready;
    logic [1:0]  ctrl_bresp;

    axi_lite_initiator #(.ADDR_WIDTH(12)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready), .ctrl_araddr(ctrl_araddr),
        .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready), .ctrl_rdata(ctrl_rdata),
        .ctrl_rresp(ctrl_rresp),
        .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready), .ctrl_awaddr(ctrl_awaddr),
        .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready), .ctrl_wdata(ctrl_wdata),
        .ctrl_wstrb(ctrl_wstrb),
        .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready), .ctrl_bresp(ctrl_bresp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // slave configuration (written by the main sequence only)
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rd_data_cfg = '0;
    logic [1:0]  rd_resp_cfg = '0;
    logic [1:0]  b_resp_cfg  = '0;

    // slave state (written by the slave process only)
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, viol;
    bit          r_pend, b_pend, aw_got, w_got;
    bit          p_arv, p_awv, p_wv, p_rr, p_br;
    logic [11:0] p_araddr, p_awaddr, ar_addr_cap, aw_addr_cap;
    logic [31:0] p_wdata, w_data_cap;
    logic [3:0]  p_wstrb, w_strb_cap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural slave: updates 1 time unit after each rising edge, using the
    // values held just before the edge to detect handshakes.
    initial begin
        bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
        ctrl_arready = 0; ctrl_rvalid = 0; ctrl_rdata = 0; ctrl_rresp = 0;
        ctrl_awready = 0; ctrl_wready = 0; ctrl_bvalid = 0; ctrl_bresp = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0; viol = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_br = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
        ar_addr_cap = 0; aw_addr_cap = 0; w_data_cap = 0; w_strb_cap = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                ctrl_arready = 0; ctrl_rvalid = 0; ctrl_awready = 0;
                ctrl_wready = 0; ctrl_bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_br = 0;
            end else begin
                ar_hs = p_arv && ctrl_arready;
                aw_hs = p_awv && ctrl_awready;
                w_hs  = p_wv  && ctrl_wready;
                r_hs  = ctrl_rvalid && p_rr;
                b_hs  = ctrl_bvalid && p_br;
                // a valid must stay up with stable payload until its handshake
                if (p_arv && !ar_hs && (!ctrl_arvalid || ctrl_araddr != p_araddr)) viol++;
                if (p_awv && !aw_hs && (!ctrl_awvalid || ctrl_awaddr != p_awaddr)) viol++;
                if (p_wv && !w_hs && (!ctrl_wvalid || ctrl_wdata != p_wdata ||
                                      ctrl_wstrb != p_wstrb)) viol++;
                if (ar_hs) begin r_pend = 1; r_cnt = 0; ar_addr_cap = p_araddr; end
                if (aw_hs) begin aw_got = 1; aw_addr_cap = p_awaddr; end
                if (w_hs)  begin w_got = 1; w_data_cap = p_wdata; w_strb_cap = p_wstrb; end
                if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
                if (r_hs) begin ctrl_rvalid = 0; r_pend = 0; end
                if (b_hs) begin ctrl_bvalid = 0; b_pend = 0; end
                if (r_pend && !ctrl_rvalid) begin
                    if (r_cnt >= r_dly) begin
                        ctrl_rvalid = 1; ctrl_rdata = rd_data_cfg; ctrl_rresp = rd_resp_cfg;
                    end else r_cnt++;
                end
                if (b_pend && !ctrl_bvalid) begin
                    if (b_cnt >= b_dly) begin
                        ctrl_bvalid = 1; ctrl_bresp = b_resp_cfg;
                    end else b_cnt++;
                end
                ctrl_arready = ctrl_arvalid && (ar_cnt >= ar_dly);
                ar_cnt       = ctrl_arvalid ? ar_cnt + 1 : 0;
                ctrl_awready = ctrl_awvalid && (aw_cnt >= aw_dly);
                aw_cnt       = ctrl_awvalid ? aw_cnt + 1 : 0;
                ctrl_wready  = ctrl_wvalid && (w_cnt >= w_dly);
                w_cnt        = ctrl_wvalid ? w_cnt + 1 : 0;
                p_arv = ctrl_arvalid; p_araddr = ctrl_araddr;
                p_awv = ctrl_awvalid; p_awaddr = ctrl_awaddr;
                p_wv  = ctrl_wvalid;  p_wdata = ctrl_wdata; p_wstrb = ctrl_wstrb;
                p_rr  = ctrl_rready;  p_br = ctrl_bready;
            end
        end
    end

    // One full command/response exchange; samples 2 time units after each edge.
    task automatic do_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                          input int exp_lat, output int awc, output int wc);
        int n;
        int lat;
        awc = 0; wc = 0;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge aclk); #2; n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge aclk); #2;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            awc += int'(ctrl_awvalid);
            wc  += int'(ctrl_wvalid);
            @(posedge aclk); #2;
            lat++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, exp_resp});
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #2;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge aclk); #2;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int awc, wc;
        bit wr;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int hold;
        aresetn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;

        // reset state
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arvalid", ctrl_arvalid, 0);
        chk("rst_awvalid", ctrl_awvalid, 0);
        chk("rst_wvalid", ctrl_wvalid, 0);
        chk("rst_rready", ctrl_rready, 0);
        chk("rst_bready", ctrl_bready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_araddr", ctrl_araddr, 0);
        aresetn = 1'b1;
        @(posedge aclk); #2;
        chk("rel_cmd_ready", cmd_ready, 1);

        // zero-wait read
        rd_data_cfg = 32'h12345678; rd_resp_cfg = 2'd0;
        do_txn(0, 12'h010, 0, 0, 0, 32'h12345678, 2'd0, 3, awc, wc);
        chk("rd_araddr", ar_addr_cap, 12'h010);

        // write, AW stalled (4 cycles of awvalid), W immediate
        aw_dly = 3; w_dly = 0; b_resp_cfg = 2'd0;
        do_txn(1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 2'd0, -1, awc, wc);
        chk("wr1_awvalid_cycles", awc, 4);
        chk("wr1_wvalid_cycles", wc, 1);
        chk("wr1_awaddr", aw_addr_cap, 12'h004);
        chk("wr1_wdata", w_data_cap, 32'hDEADBEEF);
        chk("wr1_wstrb", w_strb_cap, 4'hF);

        // zero-wait write latency
        aw_dly = 0;
        do_txn(1, 12'h008, 32'h000000A5, 4'h1, 0, 0, 2'd0, 3, awc, wc);
        chk("wr2_awvalid_cycles", awc, 1);
        chk("wr2_wstrb", w_strb_cap, 4'h1);

        // W before AW, SLVERR passed through
        aw_dly = 2; w_dly = 0; b_resp_cfg = 2'd2;
        do_txn(1, 12'h00C, 32'h55AA55AA, 4'h3, 0, 0, 2'd2, -1, awc, wc);
        chk("wr3_awvalid_cycles", awc, 3);
        chk("wr3_wvalid_cycles", wc, 1);

        // AW before W
        aw_dly = 0; w_dly = 2; b_resp_cfg = 2'd0;
        do_txn(1, 12'h100, 32'h01020304, 4'hC, 0, 0, 2'd0, -1, awc, wc);
        chk("wr4_awvalid_cycles", awc, 1);
        chk("wr4_wvalid_cycles", wc, 3);
        chk("wr4_wdata", w_data_cap, 32'h01020304);
        w_dly = 0;

        // stalled read with DECERR
        ar_dly = 2; r_dly = 1; rd_data_cfg = 32'hCAFEF00D; rd_resp_cfg = 2'd3;
        do_txn(0, 12'hFFC, 0, 0, 0, 32'hCAFEF00D, 2'd3, -1, awc, wc);
        chk("rd2_araddr", ar_addr_cap, 12'hFFC);
        ar_dly = 0; r_dly = 0; rd_resp_cfg = 2'd0;

        // response back-pressure for 5 cycles
        rd_data_cfg = 32'h0BADC0DE;
        do_txn(0, 12'h040, 0, 0, 5, 32'h0BADC0DE, 2'd0, 3, awc, wc);

        // asynchronous reset while waiting in RD_DATA
        r_dly = 20;
        cmd_write = 0; cmd_addr = 12'h020; cmd_valid = 1; rsp_ready = 1;
        @(posedge aclk); #2;
        cmd_valid = 0;
        @(posedge aclk); #2;
        chk("mid_rready", ctrl_rready, 1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_rready", ctrl_rready, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_araddr", ctrl_araddr, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        @(posedge aclk); #5;
        aresetn = 1'b1;
        r_dly = 0;
        @(posedge aclk); #2;
        chk("arel_cmd_ready", cmd_ready, 1);
        rd_data_cfg = 32'h600DF00D;
        do_txn(0, 12'h024, 0, 0, 0, 32'h600DF00D, 2'd0, 3, awc, wc);

        // randomised mix with random stalls
        for (int k = 0; k < 60; k++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 12'($urandom_range(0, 1023) * 4);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            hold   = int'($urandom_range(0, 2));
            ar_dly = int'($urandom_range(0, 3));
            r_dly  = int'($urandom_range(0, 3));
            aw_dly = int'($urandom_range(0, 3));
            w_dly  = int'($urandom_range(0, 3));
            b_dly  = int'($urandom_range(0, 3));
            rd_data_cfg = $urandom;
            rd_resp_cfg = 2'($urandom_range(0, 3));
            b_resp_cfg  = 2'($urandom_range(0, 3));
            if (wr) begin
                do_txn(1, a, d, s, hold, 0, b_resp_cfg, -1, awc, wc);
                chk("rnd_awaddr", aw_addr_cap, a);
                chk("rnd_wdata", w_data_cap, d);
                chk("rnd_wstrb", w_strb_cap, s);
                chk("rnd_awvalid_cycles", awc, aw_dly + 1);
            end else begin
                do_txn(0, a, d, s, hold, rd_data_cfg, rd_resp_cfg, -1, awc, wc);
                chk("rnd_araddr", ar_addr_cap, a);
            end
        end

        chk("valid_drop_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
